mips_multicycle_control: RTL and testbench
==========================================

# mips_multicycle_control

Multicycle control unit for the MIPS datapath: a Moore state machine that sequences fetch, decode, execute, memory and write-back. It drives the ALU's `alu_control` and operand-select lines and consumes the ALU's `zero` flag for branches. It also drives every datapath enable, handshakes with a variable-latency memory through `mem_ready`, and flags unsupported instructions.

## Interface
Parameters:
- `STATE_W`, 4, width of the `state` debug output.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `opcode`  in  6  IR[31:26].
- `funct`  in  6  IR[5:0].
- `zero`  in  1  ALU zero flag, combinational in the current cycle.
- `mem_ready`  in  1  memory access completes this cycle.
- `mem_read`, `mem_write`  out  1  memory strobes.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `ir_write`, `reg_write`  out  1  IR and register-file enables.
- `reg_dst`  out  1  destination select: 0 = rt, 1 = rd.
- `mem_to_reg`  out  1  write-back data select: 0 = ALUOut, 1 = MDR.
- `alu_src_a`  out  1  ALU A select: 0 = PC, 1 = A register.
- `alu_src_b`  out  2  ALU B select: 00 = B register, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `alu_control`  out  4  ALU operation code.
- `pc_src`  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `pc_en`  out  1  PC load enable.
- `illegal`  out  1  one-cycle pulse on an unsupported instruction.
- `state`  out  `STATE_W`  current state, for debug.

## Operation
- States: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
- Reset: state is IDLE and every output is 0, so `alu_control` = AND (0000). IDLE always moves to FETCH on the next cycle.
- Any output not listed for a state is 0 in that state.
- ALU codes: ADD 0010, SUB 0110, SLL 0011, AND 0000, OR 0001, NOR 1100, SLT 0111.
- **FETCH**
  - Outputs: `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, ADD, `pc_src`=00.
  - `ir_write` and `pc_write` are asserted only while `mem_ready`=1.
  - Holds in FETCH until `mem_ready`, then goes to DECODE.
- **DECODE**
  - Outputs: `alu_src_a`=0, `alu_src_b`=11, ADD (branch target into ALUOut).
  - Next state by opcode: 0x23 lw / 0x2B sw → MEMADR; 0x00 → EXEC if funct is supported, else FETCH with `illegal`=1; 0x04 → BRANCH; 0x08 → ADDIEX; 0x02 → JUMP; any other opcode → FETCH with `illegal`=1.
- **MEMADR**: `alu_src_a`=1, `alu_src_b`=10, ADD. Next: lw → MEMRD, sw → MEMWR.
- **MEMRD**: `mem_read`=1, `iord`=1. Holds until `mem_ready`, then MEMWB.
- **MEMWB**: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1. Next: FETCH.
- **MEMWR**: `mem_write`=1, `iord`=1. Holds until `mem_ready`, then FETCH.
- **EXEC**: `alu_src_a`=1, `alu_src_b`=00, `alu_control` from funct:
  - 0x20 → ADD, 0x22 → SUB, 0x24 → AND, 0x25 → OR, 0x27 → NOR, 0x2A → SLT, 0x00 → SLL.
  - For SLL the ALU shifts B by `shamt`.
  - Next: ALUWB.
- **ALUWB**: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0. Next: FETCH.
- **BRANCH**: `alu_src_a`=1, `alu_src_b`=00, SUB, `pc_src`=01, `branch`=1. Next: FETCH.
- **ADDIEX**: `alu_src_a`=1, `alu_src_b`=10, ADD. Next: ADDIWB.
- **ADDIWB**: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0. Next: FETCH.
- **JUMP**: `pc_src`=10, `pc_write`=1. Next: FETCH.
- PC enable: `pc_en` = `pc_write` | (`branch` & `zero`). `pc_write` and `branch` are internal signals.

## Timing
- State register updates on the `clk` rising edge; all outputs decode combinationally from state.
- Exceptions to pure Moore decode:
  - `mem_ready` gates `ir_write` and `pc_write` in FETCH.
  - `zero` gates `pc_en` in BRANCH.
  - `funct` selects `alu_control` in EXEC and the DECODE exit.
- Cycles per instruction with `mem_ready` tied to 1: R-type 4, addi 4, lw 5, sw 4, beq 3, j 3, illegal 2.
- Each wait-cycle with `mem_ready`=0 in FETCH, MEMRD or MEMWR adds one cycle. No write enable asserts during a wait.
- `zero` must settle within the BRANCH cycle; the PC commit is on the same edge as the exit from BRANCH.
- `rst_n` asserted mid-instruction: state returns to IDLE immediately and all enables drop asynchronously. No partial write may occur after reset is asserted.
- `illegal` is high only in the DECODE cycle that detects the unsupported instruction.

## Structure
- Shared package `mips_pkg`: opcode constants, funct constants, ALU-code constants, state enum.
- The ALU uses the same ALU-code constants from `mips_pkg`.
- Sub-module `alu_decoder`: combinational. Inputs: `alu_op` (00 add, 01 sub, 10 funct) and `funct`. Outputs: `alu_control` and `funct_valid`.

## Test plan
- **Reset**: reset, then release → one IDLE cycle with all outputs 0; next cycle FETCH with `mem_read`=1, `alu_control`=0010.
- **R-type**: `add` (op 0x00, funct 0x20), `mem_ready`=1 → `ir_write` and `pc_en` in cycle 1; `alu_control`=0010 in EXEC; `reg_write`=1 with `reg_dst`=1 in cycle 4. Repeat for sub, and, or, nor, slt, sll and check each `alu_control` code.
- **lw with memory stall**: `mem_ready` low for 2 cycles in MEMRD → 7 cycles total; `reg_write`=1 with `mem_to_reg`=1 exactly once.
- **beq**: `zero`=1 → `pc_en`=1 with `pc_src`=01 in BRANCH. `zero`=0 → `pc_en`=0. Both take 3 cycles.
- **Illegal instruction**: opcode 0x3F, or op 0x00 with funct 0x01 → `illegal` pulses in DECODE; no `reg_write` or `mem_write`; back in FETCH on cycle 3.
- **Reset during MEMWR stall**: assert `rst_n` low → `mem_write` drops before the next edge; after release, IDLE then FETCH.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode/funct fields, ALU operation codes and the
// multicycle control state encoding.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // ALU_OP_NONE parks the ALU on AND so idle states present all-zero outputs.
    typedef enum logic [1:0] {
        ALU_OP_ADD   = 2'b00,
        ALU_OP_SUB   = 2'b01,
        ALU_OP_FUNCT = 2'b10,
        ALU_OP_NONE  = 2'b11
    } alu_op_t;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12
    } state_t;

    function automatic logic is_mem_op(input logic [5:0] opcode);
        return (opcode == OP_LW) || (opcode == OP_SW);
    endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the multicycle control unit (master) and the datapath (slave).
interface mips_multicycle_control_if #(parameter int STATE_W = 4);
    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic               zero;
    logic               mem_ready;
    logic               mem_read;
    logic               mem_write;
    logic               iord;
    logic               ir_write;
    logic               reg_write;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [3:0]         alu_control;
    logic [1:0]         pc_src;
    logic               pc_en;
    logic               illegal;
    logic [STATE_W-1:0] state;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output mem_read, mem_write, iord, ir_write, reg_write, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, alu_control, pc_src, pc_en, illegal, state
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  mem_read, mem_write, iord, ir_write, reg_write, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, alu_control, pc_src, pc_en, illegal, state
    );
endinterface

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: maps alu_op and the R-type funct field to an ALU code.
module alu_decoder
    import mips_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [5:0] funct,
    output logic [3:0] alu_control,
    output logic       funct_valid
);

    logic [3:0] funct_alu_s;

    // funct lookup; funct_valid is independent of alu_op so DECODE can use it
    always_comb begin
        funct_valid = 1'b1;
        funct_alu_s = ALU_AND;
        case (funct)
            FN_ADD:  funct_alu_s = ALU_ADD;
            FN_SUB:  funct_alu_s = ALU_SUB;
            FN_AND:  funct_alu_s = ALU_AND;
            FN_OR:   funct_alu_s = ALU_OR;
            FN_NOR:  funct_alu_s = ALU_NOR;
            FN_SLT:  funct_alu_s = ALU_SLT;
            FN_SLL:  funct_alu_s = ALU_SLL;
            default: funct_valid = 1'b0;
        endcase
    end

    // Final operation select
    always_comb begin
        case (alu_op)
            ALU_OP_ADD:   alu_control = ALU_ADD;
            ALU_OP_SUB:   alu_control = ALU_SUB;
            ALU_OP_FUNCT: alu_control = funct_alu_s;
            default:      alu_control = ALU_AND;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM. Outputs decode from the state register; mem_ready,
// zero and funct only gate the few outputs that must react within the cycle.
module mips_multicycle_control
    import mips_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic clk,
    input  logic rst_n,
    mips_multicycle_control_if.master ctl
);

    state_t     state_r;
    state_t     state_next_s;
    alu_op_t    alu_op_s;
    logic [3:0] dec_alu_s;
    logic       funct_valid_s;
    logic       illegal_s;
    logic       pc_write_s;
    logic       branch_s;

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op_s),
        .funct       (ctl.funct),
        .alu_control (dec_alu_s),
        .funct_valid (funct_valid_s)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic and illegal-instruction detection in DECODE
    always_comb begin
        state_next_s = state_r;
        illegal_s    = 1'b0;
        case (state_r)
            S_IDLE:   state_next_s = S_FETCH;
            S_FETCH:  state_next_s = ctl.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (is_mem_op(ctl.opcode)) begin
                    state_next_s = S_MEMADR;
                end else begin
                    case (ctl.opcode)
                        OP_RTYPE: begin
                            if (funct_valid_s) begin
                                state_next_s = S_EXEC;
                            end else begin
                                state_next_s = S_FETCH;
                                illegal_s    = 1'b1;
                            end
                        end
                        OP_BEQ:  state_next_s = S_BRANCH;
                        OP_ADDI: state_next_s = S_ADDIEX;
                        OP_J:    state_next_s = S_JUMP;
                        default: begin
                            state_next_s = S_FETCH;
                            illegal_s    = 1'b1;
                        end
                    endcase
                end
            end
            S_MEMADR: begin
                if (ctl.opcode == OP_LW) begin
                    state_next_s = S_MEMRD;
                end else if (ctl.opcode == OP_SW) begin
                    state_next_s = S_MEMWR;
                end else begin
                    state_next_s = S_FETCH;
                end
            end
            S_MEMRD:  state_next_s = ctl.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_next_s = ctl.mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_next_s = S_ALUWB;
            S_ADDIEX: state_next_s = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_next_s = S_FETCH;
            default:  state_next_s = S_IDLE;
        endcase
    end

    // Per-state datapath control decode
    always_comb begin
        ctl.mem_read   = 1'b0;
        ctl.mem_write  = 1'b0;
        ctl.iord       = 1'b0;
        ctl.ir_write   = 1'b0;
        ctl.reg_write  = 1'b0;
        ctl.reg_dst    = 1'b0;
        ctl.mem_to_reg = 1'b0;
        ctl.alu_src_a  = 1'b0;
        ctl.alu_src_b  = 2'b00;
        ctl.pc_src     = 2'b00;
        alu_op_s       = ALU_OP_NONE;
        pc_write_s     = 1'b0;
        branch_s       = 1'b0;
        case (state_r)
            S_FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = 2'b01;
                alu_op_s      = ALU_OP_ADD;
                ctl.ir_write  = ctl.mem_ready;
                pc_write_s    = ctl.mem_ready;
            end
            S_DECODE: begin
                ctl.alu_src_b = 2'b11;
                alu_op_s      = ALU_OP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = 2'b10;
                alu_op_s      = ALU_OP_ADD;
            end
            S_MEMRD: begin
                ctl.mem_read = 1'b1;
                ctl.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctl.mem_write = 1'b1;
                ctl.iord      = 1'b1;
            end
            S_EXEC: begin
                ctl.alu_src_a = 1'b1;
                alu_op_s      = ALU_OP_FUNCT;
            end
            S_ALUWB: begin
                ctl.reg_write = 1'b1;
                ctl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctl.alu_src_a = 1'b1;
                alu_op_s      = ALU_OP_SUB;
                ctl.pc_src    = 2'b01;
                branch_s      = 1'b1;
            end
            S_ADDIWB: ctl.reg_write = 1'b1;
            S_JUMP: begin
                ctl.pc_src = 2'b10;
                pc_write_s = 1'b1;
            end
            default: alu_op_s = ALU_OP_NONE;
        endcase
    end

    assign ctl.alu_control = dec_alu_s;
    assign ctl.pc_en       = pc_write_s | (branch_s & ctl.zero);
    assign ctl.illegal     = illegal_s;
    assign ctl.state       = STATE_W'(state_r);

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Randomized self-checking bench: an instruction-level model expands each
// instruction into its expected cycle timeline and checks every cycle.
module tb_mips_multicycle_control;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mips_multicycle_control_if #(.STATE_W(4)) bus ();

    mips_multicycle_control #(.STATE_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctl   (bus)
    );

    typedef enum {P_IDLE, P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR,
                  P_EXEC, P_ALUWB, P_BRANCH, P_ADDIEX, P_ADDIWB, P_JUMP} phase_t;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_control;
        logic [1:0] pc_src;
        logic       pc_en;
        logic       illegal;
    } ctl_t;

    function automatic bit funct_ok(input logic [5:0] f);
        return f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25 ||
               f == 6'h27 || f == 6'h2A || f == 6'h00;
    endfunction

    function automatic logic [3:0] funct_alu(input logic [5:0] f);
        case (f)
            6'h20:   return 4'b0010;
            6'h22:   return 4'b0110;
            6'h24:   return 4'b0000;
            6'h25:   return 4'b0001;
            6'h27:   return 4'b1100;
            6'h2A:   return 4'b0111;
            6'h00:   return 4'b0011;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic ctl_t expect_ctl(input phase_t p, input logic mr, input logic z,
                                        input logic ill, input logic [5:0] fn);
        ctl_t e;
        e = '0;
        case (p)
            P_FETCH:  begin e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.alu_control = 4'b0010;
                            e.ir_write = mr; e.pc_en = mr; end
            P_DECODE: begin e.alu_src_b = 2'b11; e.alu_control = 4'b0010; e.illegal = ill; end
            P_MEMADR, P_ADDIEX:
                      begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_control = 4'b0010; end
            P_MEMRD:  begin e.mem_read = 1'b1; e.iord = 1'b1; end
            P_MEMWB:  begin e.reg_write = 1'b1; e.mem_to_reg = 1'b1; end
            P_MEMWR:  begin e.mem_write = 1'b1; e.iord = 1'b1; end
            P_EXEC:   begin e.alu_src_a = 1'b1; e.alu_control = funct_alu(fn); end
            P_ALUWB:  begin e.reg_write = 1'b1; e.reg_dst = 1'b1; end
            P_BRANCH: begin e.alu_src_a = 1'b1; e.alu_control = 4'b0110; e.pc_src = 2'b01;
                            e.pc_en = z; end
            P_ADDIWB: e.reg_write = 1'b1;
            P_JUMP:   begin e.pc_src = 2'b10; e.pc_en = 1'b1; end
            default:  e = '0;
        endcase
        return e;
    endfunction

    function automatic ctl_t sample_ctl();
        ctl_t g;
        g.mem_read = bus.mem_read;     g.mem_write = bus.mem_write;
        g.iord = bus.iord;             g.ir_write = bus.ir_write;
        g.reg_write = bus.reg_write;   g.reg_dst = bus.reg_dst;
        g.mem_to_reg = bus.mem_to_reg; g.alu_src_a = bus.alu_src_a;
        g.alu_src_b = bus.alu_src_b;   g.alu_control = bus.alu_control;
        g.pc_src = bus.pc_src;         g.pc_en = bus.pc_en;
        g.illegal = bus.illegal;
        return g;
    endfunction

    task automatic check_ctl(input string name, input ctl_t e);
        ctl_t g;
        g = sample_ctl();
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, g, e, $time);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    // Called away from a rising edge; returns 1 ns after the first FETCH edge.
    task automatic reset_sequence();
        rst_n = 1'b0;
        #1;
        check_ctl("reset_async_outputs", '0);
        check_int("reset_async_state", int'(bus.state), 0);
        check_int("reset_mem_write", int'(bus.mem_write), 0);
        @(posedge clk);
        #1;
        check_ctl("reset_held_outputs", '0);
        rst_n = 1'b1;
        @(negedge clk);
        check_ctl("idle_outputs", '0);
        check_int("idle_state", int'(bus.state), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                             input int mw, input logic zv, input bit abort,
                             output int cycles, output int rw, output logic [3:0] exec_alu);
        phase_t ph[$];
        bit     wt[$];
        bit     ill;
        logic   mr;
        logic   z;
        ctl_t   g;
        cycles   = 0;
        rw       = 0;
        exec_alu = 4'hF;
        bus.opcode = op;
        bus.funct  = fn;
        ill = 1'b0;
        for (int i = 0; i < fw; i++) begin ph.push_back(P_FETCH); wt.push_back(1'b1); end
        ph.push_back(P_FETCH);  wt.push_back(1'b0);
        ph.push_back(P_DECODE); wt.push_back(1'b0);
        if (op == 6'h23 || op == 6'h2B) begin
            ph.push_back(P_MEMADR); wt.push_back(1'b0);
            for (int i = 0; i <= mw; i++) begin
                ph.push_back(op == 6'h23 ? P_MEMRD : P_MEMWR);
                wt.push_back(i < mw);
            end
            if (op == 6'h23) begin ph.push_back(P_MEMWB); wt.push_back(1'b0); end
        end else if (op == 6'h00 && funct_ok(fn)) begin
            ph.push_back(P_EXEC);  wt.push_back(1'b0);
            ph.push_back(P_ALUWB); wt.push_back(1'b0);
        end else if (op == 6'h04) begin
            ph.push_back(P_BRANCH); wt.push_back(1'b0);
        end else if (op == 6'h08) begin
            ph.push_back(P_ADDIEX); wt.push_back(1'b0);
            ph.push_back(P_ADDIWB); wt.push_back(1'b0);
        end else if (op == 6'h02) begin
            ph.push_back(P_JUMP); wt.push_back(1'b0);
        end else begin
            ill = 1'b1;
        end
        for (int k = 0; k < ph.size(); k++) begin
            if (ph[k] == P_FETCH || ph[k] == P_MEMRD || ph[k] == P_MEMWR)
                mr = !wt[k];
            else
                mr = 1'($urandom_range(0, 1));
            z = (ph[k] == P_BRANCH) ? zv : 1'($urandom_range(0, 1));
            bus.mem_ready = mr;
            bus.zero      = z;
            @(negedge clk);
            check_ctl(ph[k].name(), expect_ctl(ph[k], mr, z, ill, fn));
            g = sample_ctl();
            cycles++;
            if (g.reg_write) rw++;
            if (ph[k] == P_EXEC) exec_alu = g.alu_control;
            if (abort && ph[k] == P_MEMWR && wt[k]) begin
                #1;
                reset_sequence();
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    logic [5:0] r_functs [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00};
    logic [3:0] r_codes  [7] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111, 4'b0011};
    logic [5:0] legal_ops [6] = '{6'h00, 6'h02, 6'h04, 6'h08, 6'h23, 6'h2B};

    initial begin
        int         cyc;
        int         rw;
        logic [3:0] ea;
        logic [5:0] op;
        logic [5:0] fn;
        bit         legal;
        bus.opcode    = 6'h00;
        bus.funct     = 6'h20;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        #2;
        reset_sequence();
        check_int("fetch_alu_code_literal", int'(bus.alu_control), 2);
        check_int("fetch_mem_read_literal", int'(bus.mem_read), 1);

        for (int i = 0; i < 7; i++) begin
            run_instr(6'h00, r_functs[i], 0, 0, 1'b0, 1'b0, cyc, rw, ea);
            check_int("rtype_cycles", cyc, 4);
            check_int("rtype_alu_code", int'(ea), int'(r_codes[i]));
            check_int("rtype_reg_write_count", rw, 1);
        end
        run_instr(6'h23, 6'h15, 0, 2, 1'b0, 1'b0, cyc, rw, ea);
        check_int("lw_stall_cycles", cyc, 7);
        check_int("lw_reg_write_count", rw, 1);
        run_instr(6'h2B, 6'h00, 0, 0, 1'b0, 1'b0, cyc, rw, ea);
        check_int("sw_cycles", cyc, 4);
        check_int("sw_reg_write_count", rw, 0);
        run_instr(6'h04, 6'h00, 0, 0, 1'b1, 1'b0, cyc, rw, ea);
        check_int("beq_taken_cycles", cyc, 3);
        run_instr(6'h04, 6'h00, 0, 0, 1'b0, 1'b0, cyc, rw, ea);
        check_int("beq_not_taken_cycles", cyc, 3);
        run_instr(6'h08, 6'h00, 0, 0, 1'b0, 1'b0, cyc, rw, ea);
        check_int("addi_cycles", cyc, 4);
        run_instr(6'h02, 6'h00, 0, 0, 1'b0, 1'b0, cyc, rw, ea);
        check_int("j_cycles", cyc, 3);
        run_instr(6'h3F, 6'h20, 0, 0, 1'b0, 1'b0, cyc, rw, ea);
        check_int("illegal_op_cycles", cyc, 2);
        check_int("illegal_op_reg_write", rw, 0);
        run_instr(6'h00, 6'h01, 0, 0, 1'b0, 1'b0, cyc, rw, ea);
        check_int("illegal_funct_cycles", cyc, 2);
        run_instr(6'h23, 6'h00, 2, 1, 1'b0, 1'b0, cyc, rw, ea);
        check_int("lw_fetch_stall_cycles", cyc, 8);
        run_instr(6'h2B, 6'h00, 0, 3, 1'b0, 1'b1, cyc, rw, ea);

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 7))
                0: begin op = 6'h00; fn = r_functs[$urandom_range(0, 6)]; end
                1: begin
                    op = 6'h00;
                    fn = 6'($urandom);
                    while (funct_ok(fn)) fn = 6'($urandom);
                end
                2: begin op = 6'h23; fn = 6'($urandom); end
                3: begin op = 6'h2B; fn = 6'($urandom); end
                4: begin op = 6'h04; fn = 6'($urandom); end
                5: begin op = 6'h08; fn = 6'($urandom); end
                6: begin op = 6'h02; fn = 6'($urandom); end
                default: begin
                    fn = 6'($urandom);
                    legal = 1'b1;
                    op = 6'h00;
                    while (legal) begin
                        op = 6'($urandom);
                        legal = 1'b0;
                        foreach (legal_ops[j]) if (legal_ops[j] == op) legal = 1'b1;
                    end
                end
            endcase
            run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 2),
                      1'($urandom_range(0, 1)), 1'b0, cyc, rw, ea);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
